// File: rtl/booth_seqdiv.sv
// Multi-cycle signed divider: restoring radix-2 division on operand magnitudes,
// signs applied at the end. Optional divide-by-zero shortcut: BOOTH_SEQDIV_DBZ_EN.
module booth_seqdiv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             dbz,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] ymag;
    logic [WIDTH:0]   rem;
    logic [CW-1:0]    cnt;
    logic             sq;
    logic             sr;

    logic [WIDTH-1:0] xmag_in;
    logic [WIDTH-1:0] ymag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             unused_rem_msb;

    // Negating the most negative value yields 2^(WIDTH-1), exact as unsigned.
    assign xmag_in = X[WIDTH-1] ? (~X + 1'b1) : X;
    assign ymag_in = Y[WIDTH-1] ? (~Y + 1'b1) : Y;

    // The running remainder always stays below |Y|, so its top bit never feeds the shift.
    assign shifted        = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign trial          = {1'b0, shifted} - {2'b00, ymag};
    assign unused_rem_msb = rem[WIDTH];
    assign dbg_state      = state;

`ifdef BOOTH_SEQDIV_DBZ_EN
    logic dbz_q;
    logic dbz_pend;
    assign dbz = dbz_q;
`else
    assign dbz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            quo   <= '0;
            ymag  <= '0;
            rem   <= '0;
            cnt   <= '0;
            sq    <= 1'b0;
            sr    <= 1'b0;
`ifdef BOOTH_SEQDIV_DBZ_EN
            dbz_q    <= 1'b0;
            dbz_pend <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quo   <= xmag_in;
                        ymag  <= ymag_in;
                        rem   <= '0;
                        cnt   <= CW'(WIDTH);
                        sq    <= X[WIDTH-1] ^ Y[WIDTH-1];
                        sr    <= X[WIDTH-1];
                        busy  <= 1'b1;
                        state <= S_CALC;
`ifdef BOOTH_SEQDIV_DBZ_EN
                        dbz_q    <= 1'b0;
                        dbz_pend <= (Y == '0);
                        // A zero divisor spends one idle CALC cycle, leaving quo = |X|.
                        if (Y == '0) cnt <= CW'(1);
`endif
                    end
                end
                S_CALC: begin
`ifdef BOOTH_SEQDIV_DBZ_EN
                    if (!dbz_pend) begin
`else
                    begin
`endif
                        if (!trial[WIDTH+1]) begin
                            rem <= trial[WIDTH:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted;
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) state <= S_FIX;
                end
                S_FIX: begin
`ifdef BOOTH_SEQDIV_DBZ_EN
                    if (dbz_pend) begin
                        Q     <= '1;
                        R     <= sr ? (~quo + 1'b1) : quo;
                        dbz_q <= 1'b1;
                    end else begin
`else
                    begin
`endif
                        Q <= sq ? (~quo + 1'b1) : quo;
                        R <= sr ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seqdiv.sv
// Scoreboard bench for booth_seqdiv: directed vectors with hand-computed results,
// checked by an independent monitor on every done pulse.
module tb_booth_seqdiv;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         dbz;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int cyc      = 0;

    logic [2*W:0] exp_q[$];
    int           lat_q[$];
    int           st_q[$];

`ifdef BOOTH_SEQDIV_DBZ_EN
    localparam int  DBZ_LAT = 2;
    localparam logic DBZ_FLAG = 1'b1;
`else
    localparam int  DBZ_LAT = 17;
    localparam logic DBZ_FLAG = 1'b0;
`endif

    booth_seqdiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .X         (X),
        .Y         (Y),
        .busy      (busy),
        .done      (done),
        .Q         (Q),
        .R         (R),
        .dbz       (dbz),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1, expected no result pending (cycle %0d)", cyc);
            end else begin
                logic [2*W:0] e;
                int           lat;
                int           st;
                e   = exp_q.pop_front();
                lat = lat_q.pop_front();
                st  = st_q.pop_front();
                chk("Q", 32'(Q), 32'(e[2*W:W+1]));
                chk("R", 32'(R), 32'(e[W:1]));
                chk("dbz", 32'(dbz), 32'(e[0]));
                chk("latency", 32'(cyc - st), 32'(lat));
            end
        end
    end

    // driver tasks
    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ed, input int lat);
        @(negedge clk);
        X = x;
        Y = y;
        start = 1'b1;
        exp_q.push_back({eq, er, ed});
        lat_q.push_back(lat);
        st_q.push_back(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        X = $urandom_range(0, 65535);
        Y = $urandom_range(0, 65535);
    endtask

    task automatic wait_done(input int prev, input bit chk_busy, input logic [W-1:0] eq);
        int k = 0;
        while (n_done == prev && k < 60) begin
            if (chk_busy) chk("busy_during", 32'(busy), 32'd1);
            @(negedge clk);
            #1;
            k++;
        end
        if (n_done == prev) begin
            chk("done_timeout", 32'(n_done), 32'(prev + 1));
            exp_q.delete();
            lat_q.delete();
            st_q.delete();
        end else begin
            @(negedge clk);
            #1;
            chk("done_pulse", 32'(done), 32'd0);
            chk("busy_after", 32'(busy), 32'd0);
            chk("Q_hold", 32'(Q), 32'(eq));
        end
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ed, input int lat, input bit chk_busy);
        int prev;
        prev = n_done;
        issue(x, y, eq, er, ed, lat);
        wait_done(prev, chk_busy, eq);
    endtask

    initial begin
        int prev;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_Q", 32'(Q), 32'd0);
        chk("rst_R", 32'(R), 32'd0);
        chk("rst_dbz", 32'(dbz), 32'd0);
        rst = 1'b0;

        // basic and sign combinations
        run_op(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 17, 1'b1);
        run_op(-16'sd100, 16'd7, -16'sd14, -16'sd2, 1'b0, 17, 1'b0);
        run_op(16'd100, -16'sd7, -16'sd14, 16'd2, 1'b0, 17, 1'b0);
        run_op(-16'sd100, -16'sd7, 16'd14, -16'sd2, 1'b0, 17, 1'b0);

        // extremes
        run_op(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 17, 1'b0);
        run_op(16'h8000, 16'd1, 16'h8000, 16'd0, 1'b0, 17, 1'b0);
        run_op(16'd3, 16'd5, 16'd0, 16'd3, 1'b0, 17, 1'b0);
        run_op(16'd32767, 16'h8000, 16'd0, 16'd32767, 1'b0, 17, 1'b0);
        run_op(16'h8000, 16'h8000, 16'd1, 16'd0, 1'b0, 17, 1'b0);

        // start while busy is dropped
        prev = n_done;
        issue(16'd1234, 16'd11, 16'd112, 16'd2, 1'b0, 17);
        repeat (4) @(negedge clk);
        X = 16'd50;
        Y = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(prev, 1'b0, 16'd112);
        repeat (20) @(negedge clk);

        // reset mid-operation
        @(negedge clk);
        X = 16'd999;
        Y = 16'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_Q", 32'(Q), 32'd0);
        chk("midrst_R", 32'(R), 32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_op(-16'sd7, 16'd2, -16'sd3, -16'sd1, 1'b0, 17, 1'b0);

        // divide by zero
        run_op(16'd5, 16'd0, 16'hFFFF, 16'd5, DBZ_FLAG, DBZ_LAT, 1'b1);
`ifdef BOOTH_SEQDIV_DBZ_EN
        run_op(-16'sd5, 16'd0, 16'hFFFF, -16'sd5, 1'b1, 2, 1'b0);
`else
        run_op(-16'sd5, 16'd0, 16'd1, -16'sd5, 1'b0, 17, 1'b0);
`endif
        run_op(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 17, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
